// File: rtl/imm_encoder_loader_pkg.sv
// Shared types and constants for the immediate encoder / instruction-memory loader.
package imm_encoder_loader_pkg;

    typedef enum logic [2:0] {
        FMT_R = 3'd0,
        FMT_I = 3'd1,
        FMT_S = 3'd2,
        FMT_B = 3'd3,
        FMT_J = 3'd4,
        FMT_U = 3'd5
    } fmt_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_FULL  = 2'd3
    } state_e;

    localparam logic [1:0] ERR_NONE     = 2'd0;
    localparam logic [1:0] ERR_RANGE    = 2'd1;
    localparam logic [1:0] ERR_MISALIGN = 2'd2;
    localparam logic [1:0] ERR_FMT      = 2'd3;

    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    // Signed inclusive interval test on a two's-complement immediate.
    function automatic logic imm_in_range(input logic [31:0] v, input int lo, input int hi);
        return ($signed(v) >= lo) && ($signed(v) <= hi);
    endfunction

endpackage

// File: rtl/imm_encoder_loader_imm_pack.sv
// Combinational packer: scatters a full immediate into the instruction layout of
// the selected format and flags values the format cannot represent.
module imm_pack
    import imm_encoder_loader_pkg::*;
(
    input  logic [2:0]  fmt_i,
    input  logic [6:0]  opcode_i,
    input  logic [4:0]  rd_i,
    input  logic [4:0]  rs1_i,
    input  logic [4:0]  rs2_i,
    input  logic [2:0]  funct3_i,
    input  logic [6:0]  funct7_i,
    input  logic [31:0] imm_i,
    output logic [31:0] word_o,
    output logic        range_err_o,
    output logic        misalign_err_o,
    output logic        fmt_err_o
);

    always_comb begin
        word_o         = '0;
        range_err_o    = 1'b0;
        misalign_err_o = 1'b0;
        fmt_err_o      = 1'b0;
        case (fmt_i)
            FMT_R: word_o = {funct7_i, rs2_i, rs1_i, funct3_i, rd_i, opcode_i};
            FMT_I: begin
                word_o      = {imm_i[11:0], rs1_i, funct3_i, rd_i, opcode_i};
                range_err_o = !imm_in_range(imm_i, -2048, 2047);
            end
            FMT_S: begin
                word_o      = {imm_i[11:5], rs2_i, rs1_i, funct3_i, imm_i[4:0], opcode_i};
                range_err_o = !imm_in_range(imm_i, -2048, 2047);
            end
            FMT_B: begin
                word_o         = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, funct3_i,
                                  imm_i[4:1], imm_i[11], opcode_i};
                range_err_o    = !imm_in_range(imm_i, -4096, 4094);
                misalign_err_o = imm_i[0];
            end
            FMT_J: begin
                word_o         = {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12], rd_i, opcode_i};
                range_err_o    = !imm_in_range(imm_i, -1048576, 1048574);
                misalign_err_o = imm_i[0];
            end
            FMT_U: begin
                word_o         = {imm_i[31:12], rd_i, opcode_i};
                misalign_err_o = |imm_i[11:0];
            end
            default: fmt_err_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/imm_encoder_loader.sv
// Loader session FSM: accepts field bundles, registers the encoded word and streams
// it to instruction memory at consecutive word addresses, one word per cycle.
module imm_encoder_loader
    import imm_encoder_loader_pkg::*;
#(
    parameter int ADDR_W    = 10,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              stop,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        fmt,
    input  logic [6:0]        opcode,
    input  logic [4:0]        rd,
    input  logic [4:0]        rs1,
    input  logic [4:0]        rs2,
    input  logic [2:0]        funct3,
    input  logic [6:0]        funct7,
    input  logic [31:0]       imm,
    output logic              mem_wr_en,
    input  logic              mem_ready,
    output logic [ADDR_W-1:0] mem_wr_addr,
    output logic [31:0]       mem_wr_data,
    output logic              busy,
    output logic              full,
    output logic [ADDR_W:0]   count,
    output logic              err,
    output logic [1:0]        err_code
);

    localparam logic [ADDR_W-1:0] BASE    = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] LAST    = '1;
    localparam logic [ADDR_W:0]   CNT_ONE = {{ADDR_W{1'b0}}, 1'b1};

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              wr_en_q, wr_en_d;
    logic [31:0]       data_q, data_d;
    logic              err_q, err_d;
    logic [1:0]        err_code_q, err_code_d;

    logic [31:0] enc_word;
    logic        enc_range, enc_misalign, enc_fmt;
    logic        accept, complete, last_pending;

    imm_pack u_imm_pack (
        .fmt_i          (fmt),
        .opcode_i       (opcode),
        .rd_i           (rd),
        .rs1_i          (rs1),
        .rs2_i          (rs2),
        .funct3_i       (funct3),
        .funct7_i       (funct7),
        .imm_i          (imm),
        .word_o         (enc_word),
        .range_err_o    (enc_range),
        .misalign_err_o (enc_misalign),
        .fmt_err_o      (enc_fmt)
    );

    assign accept       = in_valid & in_ready;
    assign complete     = wr_en_q & mem_ready;
    // While the final address is in flight nothing more may be accepted, or it would wrap.
    assign last_pending = wr_en_q && (addr_q == LAST);

    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (start) state_d = ST_RUN;
            ST_RUN: begin
                if (complete && last_pending) state_d = stop ? ST_IDLE : ST_FULL;
                else if (stop)                state_d = ST_DRAIN;
            end
            ST_DRAIN: if (!wr_en_q || complete) state_d = ST_IDLE;
            ST_FULL:  if (stop) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        in_ready = (state_q == ST_RUN) && (!wr_en_q || mem_ready) && !last_pending;
        busy     = (state_q != ST_IDLE);
        full     = (state_q == ST_FULL);
    end

    always_comb begin
        addr_d     = addr_q;
        count_d    = count_q;
        wr_en_d    = wr_en_q;
        data_d     = data_q;
        err_d      = err_q;
        err_code_d = err_code_q;
        if (state_q == ST_IDLE && start) begin
            addr_d     = BASE;
            count_d    = '0;
            err_d      = 1'b0;
            err_code_d = ERR_NONE;
        end
        if (complete) begin
            wr_en_d = 1'b0;
            addr_d  = addr_q + 1'b1;
            count_d = count_q + CNT_ONE;
        end
        if (accept) begin
            if (enc_range || enc_misalign || enc_fmt) begin
                err_d = 1'b1;
                if (!err_q) begin
                    err_code_d = enc_range    ? ERR_RANGE :
                                 enc_misalign ? ERR_MISALIGN : ERR_FMT;
                end
            end else begin
                wr_en_d = 1'b1;
                data_d  = enc_word;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q     <= '0;
            count_q    <= '0;
            wr_en_q    <= 1'b0;
            data_q     <= '0;
            err_q      <= 1'b0;
            err_code_q <= ERR_NONE;
        end else begin
            addr_q     <= addr_d;
            count_q    <= count_d;
            wr_en_q    <= wr_en_d;
            data_q     <= data_d;
            err_q      <= err_d;
            err_code_q <= err_code_d;
        end
    end

    assign mem_wr_en   = wr_en_q;
    assign mem_wr_addr = addr_q;
    assign mem_wr_data = data_q;
    assign count       = count_q;
    assign err         = err_q;
    assign err_code    = err_code_q;

endmodule

// File: tb/tb_imm_encoder_loader.sv
// Directed and randomized bench for imm_encoder_loader against an arithmetic encoding model.
module tb_imm_encoder_loader;
    import imm_encoder_loader_pkg::*;

    localparam int ADDR_W    = 2;
    localparam int BASE_ADDR = 0;
    localparam int DEPTH     = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              rst, start, stop, in_valid, in_ready;
    logic [2:0]        fmt;
    logic [6:0]        opcode, funct7;
    logic [4:0]        rd, rs1, rs2;
    logic [2:0]        funct3;
    logic [31:0]       imm;
    logic              mem_wr_en, mem_ready;
    logic [ADDR_W-1:0] mem_wr_addr;
    logic [31:0]       mem_wr_data;
    logic              busy, full, err;
    logic [ADDR_W:0]   count;
    logic [1:0]        err_code;

    imm_encoder_loader #(.ADDR_W(ADDR_W), .BASE_ADDR(BASE_ADDR)) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop),
        .in_valid(in_valid), .in_ready(in_ready),
        .fmt(fmt), .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2),
        .funct3(funct3), .funct7(funct7), .imm(imm),
        .mem_wr_en(mem_wr_en), .mem_ready(mem_ready),
        .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
        .busy(busy), .full(full), .count(count), .err(err), .err_code(err_code)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    int          checks   = 0;
    int          failures = 0;
    int          cycle    = 0;
    wr_t         exp_q[$];
    int          done_cycles[$];
    wr_t         mon_e;
    logic [31:0] last_word;
    int          model_addr, model_cnt, model_err, model_code;

    always @(posedge clk) cycle <= cycle + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Each completing write is matched against the next expected (addr, data).
    always @(negedge clk) begin
        if (rst === 1'b0 && mem_wr_en === 1'b1 && mem_ready === 1'b1) begin
            check("write_expected", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) begin
                mon_e = exp_q.pop_front();
                check("wr_addr", 32'(mem_wr_addr), mon_e.addr);
                check("wr_data", mem_wr_data, mon_e.data);
            end
            $display("write addr=%0d data=0x%08h cycle=%0d", mem_wr_addr, mem_wr_data, cycle);
            last_word = mem_wr_data;
            done_cycles.push_back(cycle);
        end
    end

    // Reference: field placement by shifts and masks, range rules as integer intervals.
    function automatic void ref_encode(input logic [31:0] f, op, d, s1, s2, f3, f7, im,
                                       output logic [31:0] w, output int e);
        longint v = longint'($signed(im));
        w = 32'd0;
        e = 0;
        case (f)
            0: w = (f7 << 25) | (s2 << 20) | (s1 << 15) | (f3 << 12) | (d << 7) | op;
            1: begin
                if (v < -2048 || v > 2047) e = 1;
                w = ((im & 32'hFFF) << 20) | (s1 << 15) | (f3 << 12) | (d << 7) | op;
            end
            2: begin
                if (v < -2048 || v > 2047) e = 1;
                w = (((im >> 5) & 32'h7F) << 25) | (s2 << 20) | (s1 << 15) | (f3 << 12)
                  | ((im & 32'h1F) << 7) | op;
            end
            3: begin
                if (v < -4096 || v > 4094) e = 1;
                else if (im % 2 != 0)      e = 2;
                w = (((im >> 12) & 1) << 31) | (((im >> 5) & 32'h3F) << 25) | (s2 << 20)
                  | (s1 << 15) | (f3 << 12) | (((im >> 1) & 32'hF) << 8)
                  | (((im >> 11) & 1) << 7) | op;
            end
            4: begin
                if (v < -1048576 || v > 1048574) e = 1;
                else if (im % 2 != 0)            e = 2;
                w = (((im >> 20) & 1) << 31) | (((im >> 1) & 32'h3FF) << 21)
                  | (((im >> 11) & 1) << 20) | (((im >> 12) & 32'hFF) << 12) | (d << 7) | op;
            end
            5: begin
                if ((im % 4096) != 0) e = 2;
                w = (im & 32'hFFFFF000) | (d << 7) | op;
            end
            default: e = 3;
        endcase
    endfunction

    task automatic send(input bit with_stop, input bit rand_ready);
        bit acc = 1'b0;
        in_valid = 1'b1;
        stop     = with_stop;
        for (int i = 0; i < 60 && !acc; i++) begin
            if (rand_ready) mem_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            acc = (in_ready === 1'b1);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        stop     = 1'b0;
        check("accept_timeout", 32'(acc), 32'd1);
    endtask

    task automatic model_and_send(input logic [31:0] f, op, d, s1, s2, f3, f7, im,
                                  input bit with_stop, input bit rand_ready);
        logic [31:0] w;
        int          e;
        ref_encode(f, op, d, s1, s2, f3, f7, im, w, e);
        fmt = f[2:0]; opcode = op[6:0]; rd = d[4:0]; rs1 = s1[4:0]; rs2 = s2[4:0];
        funct3 = f3[2:0]; funct7 = f7[6:0]; imm = im;
        if (e == 0) begin
            exp_q.push_back('{32'(model_addr), w});
            model_addr = (model_addr + 1) % DEPTH;
            model_cnt++;
        end else if (model_err == 0) begin
            model_err  = 1;
            model_code = e;
        end
        $display("bundle fmt=%0d imm=0x%08h err=%0d expect_word=0x%08h", f, im, e, w);
        send(with_stop, rand_ready);
    endtask

    task automatic wait_empty();
        mem_ready = 1'b1;
        for (int i = 0; i < 100 && exp_q.size() > 0; i++) begin
            @(posedge clk);
            #1;
        end
        check("drain_timeout", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic do_start();
        start = 1'b1;
        @(posedge clk);
        #1;
        start      = 1'b0;
        model_addr = BASE_ADDR;
        model_cnt  = 0;
        model_err  = 0;
        model_code = 0;
        done_cycles.delete();
    endtask

    task automatic do_stop();
        stop = 1'b1;
        @(posedge clk);
        #1;
        stop = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        check("busy_after_stop", 32'(busy), 32'd0);
    endtask

    function automatic logic [31:0] pick_imm();
        int edges[16] = '{-2048, 2047, -2049, 2048, -4096, 4094, 4095, 4096,
                          -4097, -4098, -1048576, 1048574, 1048575, 1048576, -1048578, 0};
        case ($urandom_range(0, 3))
            0:       return 32'(edges[$urandom_range(0, 15)]);
            1:       return 32'($urandom_range(0, 10000)) - 32'd5000;
            2:       return $urandom();
            default: return ($urandom() & 32'hFFFFF000) | 32'($urandom_range(0, 1));
        endcase
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog expired before completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; start = 1'b0; stop = 1'b0; in_valid = 1'b0; mem_ready = 1'b0;
        fmt = '0; opcode = '0; rd = '0; rs1 = '0; rs2 = '0; funct3 = '0; funct7 = '0; imm = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_wr_en", 32'(mem_wr_en), 0);
        check("rst_addr", 32'(mem_wr_addr), 0);
        check("rst_data", mem_wr_data, 0);
        check("rst_count", 32'(count), 0);
        check("rst_full", 32'(full), 0);
        check("rst_err", 32'(err), 0);
        check("rst_err_code", 32'(err_code), 0);
        check("rst_in_ready", 32'(in_ready), 0);
        check("rst_busy", 32'(busy), 0);
        rst = 1'b0;
        mem_ready = 1'b1;

        // Session 1: I-type, then S-type with stop in the accept cycle.
        do_start();
        check("s1_busy", 32'(busy), 1);
        check("s1_in_ready", 32'(in_ready), 1);
        exp_q.push_back('{32'(BASE_ADDR), 32'hFFF30293});
        fmt = 3'd1; opcode = OP_IMM; rd = 5'd5; rs1 = 5'd6; rs2 = 5'd0; funct3 = 3'd0;
        funct7 = 7'd0; imm = 32'hFFFF_FFFF;
        send(1'b0, 1'b0);
        wait_empty();
        check("s1_count_after_i", 32'(count), 1);
        exp_q.push_back('{32'(BASE_ADDR + 1), 32'h0020A423});
        fmt = 3'd2; opcode = OP_STORE; rd = 5'd0; rs1 = 5'd1; rs2 = 5'd2; funct3 = 3'd2;
        imm = 32'd8;
        send(1'b1, 1'b0);
        wait_empty();
        check("s_imm_decode", {{20{last_word[31]}}, last_word[31:25], last_word[11:7]}, 32'd8);
        @(posedge clk);
        #1;
        check("s1_busy_end", 32'(busy), 0);
        check("s1_count_end", 32'(count), 2);

        // Session 2: back-to-back B/J, error recovery, fill to full.
        do_start();
        exp_q.push_back('{32'd0, 32'hFE000EE3});
        exp_q.push_back('{32'd1, 32'h001000EF});
        fmt = 3'd3; opcode = OP_BRANCH; rd = 5'd0; rs1 = 5'd0; rs2 = 5'd0; funct3 = 3'd0;
        imm = 32'hFFFF_FFFC;
        send(1'b0, 1'b0);
        fmt = 3'd4; opcode = OP_JAL; rd = 5'd1; imm = 32'd2048;
        send(1'b0, 1'b0);
        model_addr = 2;
        model_cnt  = 2;
        wait_empty();
        check("bj_writes", 32'(done_cycles.size()), 2);
        check("bj_no_bubble", 32'(done_cycles[1] - done_cycles[0]), 1);
        model_and_send(3, OP_BRANCH, 0, 1, 2, 0, 0, 3, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        check("err_no_write", 32'(mem_wr_en), 0);
        check("err_flag", 32'(err), 1);
        check("err_code_misalign", 32'(err_code), 2);
        check("err_count_held", 32'(count), 2);
        model_and_send(1, OP_IMM, 3, 4, 0, 1, 0, 2047, 1'b0, 1'b0);
        model_and_send(7, OP_IMM, 3, 4, 0, 1, 0, 0, 1'b0, 1'b0);
        check("err_code_sticky", 32'(err_code), 2);
        model_and_send(5, OP_LUI, 9, 0, 0, 0, 0, 32'h12345000, 1'b0, 1'b0);
        wait_empty();
        @(posedge clk);
        #1;
        check("full_flag", 32'(full), 1);
        check("full_count", 32'(count), 4);
        check("full_in_ready", 32'(in_ready), 0);
        check("full_busy", 32'(busy), 1);
        do_stop();
        check("full_cleared", 32'(full), 0);

        // Session 3: range precedence and J boundaries.
        do_start();
        model_and_send(3, OP_BRANCH, 0, 1, 2, 0, 0, 5001, 1'b0, 1'b0);
        check("err_code_range_first", 32'(err_code), 1);
        model_and_send(4, OP_JAL, 1, 0, 0, 0, 0, 1048574, 1'b0, 1'b0);
        model_and_send(4, OP_JAL, 1, 0, 0, 0, 0, 1048576, 1'b0, 1'b0);
        model_and_send(5, OP_LUI, 1, 0, 0, 0, 0, 32'h12345001, 1'b0, 1'b0);
        wait_empty();
        @(posedge clk);
        #1;
        check("s3_count", 32'(count), 32'(model_cnt));
        check("s3_err_code", 32'(err_code), 1);
        do_stop();

        // Session 4: backpressure, then reset during a stalled write.
        do_start();
        mem_ready = 1'b0;
        model_and_send(1, OP_IMM, 7, 8, 0, 0, 0, 100, 1'b0, 1'b0);
        in_valid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("stall_wr_en", 32'(mem_wr_en), 1);
            check("stall_addr", 32'(mem_wr_addr), 0);
            check("stall_data", mem_wr_data, exp_q[0].data);
            check("stall_in_ready", 32'(in_ready), 0);
            @(posedge clk);
            #1;
        end
        in_valid  = 1'b0;
        mem_ready = 1'b1;
        model_and_send(2, OP_STORE, 0, 3, 4, 2, 0, 32'hFFFF_F800, 1'b0, 1'b0);
        wait_empty();
        @(posedge clk);
        #1;
        check("bp_count", 32'(count), 2);
        mem_ready = 1'b0;
        model_and_send(1, OP_IMM, 2, 2, 0, 0, 0, 1, 1'b0, 1'b0);
        check("stalled_before_rst", 32'(mem_wr_en), 1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        exp_q.delete();
        check("rst2_wr_en", 32'(mem_wr_en), 0);
        check("rst2_addr", 32'(mem_wr_addr), 0);
        check("rst2_data", mem_wr_data, 0);
        check("rst2_count", 32'(count), 0);
        check("rst2_busy", 32'(busy), 0);
        check("rst2_in_ready", 32'(in_ready), 0);
        rst = 1'b0;
        mem_ready = 1'b1;
        do_start();
        model_and_send(0, 7'b0110011, 1, 2, 3, 0, 7'b0100000, 0, 1'b0, 1'b0);
        wait_empty();
        @(posedge clk);
        #1;
        check("restart_count", 32'(count), 1);
        do_stop();

        // Randomized sessions with random memory backpressure.
        for (int s = 0; s < 12; s++) begin
            int limit = $urandom_range(3, 10);
            do_start();
            for (int n = 0; n < limit && model_cnt < DEPTH; n++) begin
                model_and_send($urandom_range(0, 7), $urandom_range(0, 127), $urandom_range(0, 31),
                               $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 7),
                               $urandom_range(0, 127), pick_imm(), 1'b0, 1'b1);
            end
            wait_empty();
            @(posedge clk);
            #1;
            check("rnd_count", 32'(count), 32'(model_cnt));
            check("rnd_full", 32'(full), 32'(model_cnt == DEPTH));
            check("rnd_err", 32'(err), 32'(model_err));
            check("rnd_err_code", 32'(err_code), 32'(model_code));
            do_stop();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/imm_encoder_loader.md
Name: imm_encoder_loader

Overview:
- Inverse of the core's immediate generator.
- Takes decoded instruction fields plus a full 32-bit immediate over a valid/ready stream.
- Range-checks the immediate, packs it into the R/I/S/B/J/U bit layout, and streams the finished 32-bit words into the instruction-memory write port at consecutive word addresses.
- Used by the test loader/boot path to fill instruction memory before the single-cycle core runs.

Parameters:
ADDR_W, 10, instruction-memory word-address width
BASE_ADDR, 0, first word address written after start

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
start  in  1  pulse: begin a load session (honoured only in IDLE)
stop  in  1  pulse: end session after any pending write drains
in_valid  in  1  field bundle valid
in_ready  out  1  block can accept bundle
fmt  in  3  0=R 1=I 2=S 3=B 4=J 5=U; 6,7 illegal
opcode  in  7  opcode field
rd  in  5  destination register
rs1  in  5  source register 1
rs2  in  5  source register 2
funct3  in  3  funct3 field
funct7  in  7  funct7 field (R only)
imm  in  32  full signed immediate/offset (byte units for B/J)
mem_wr_en  out  1  write strobe
mem_ready  in  1  memory accepts the write this cycle
mem_wr_addr  out  ADDR_W  word address
mem_wr_data  out  32  encoded instruction
busy  out  1  state != IDLE
full  out  1  last address written
count  out  ADDR_W+1  words written this session
err  out  1  sticky: an encoding error occurred this session
err_code  out  2  first error: 1=range, 2=misaligned, 3=illegal fmt

Behaviour:
- Reset: state IDLE. All outputs 0: mem_wr_en, mem_wr_addr, mem_wr_data, count, full, err, err_code, in_ready.
- States:
  - IDLE: start -> RUN, address=BASE_ADDR, count=0, err=0.
  - RUN: accept bundles. stop -> DRAIN.
  - DRAIN: wait until no write is pending, then -> IDLE.
  - FULL: entered when a write to address 2^ADDR_W-1 completes; full=1, in_ready=0; stop -> IDLE.
- Handshake and pipeline:
  - Bundle accepted when in_valid & in_ready.
  - in_ready = (state==RUN) & (!mem_wr_en | mem_ready).
  - Encoding is registered: accept in cycle N -> mem_wr_en=1 in N+1 with data/address held stable until mem_ready.
  - Write completes on mem_wr_en & mem_ready. Completion advances the address and count and may coincide with a new accept (full throughput: one word per cycle).
- Encoding:
  - R: funct7|rs2|rs1|funct3|rd|opcode.
  - I: imm[11:0]|rs1|funct3|rd|opcode.
  - S: imm[11:5]|rs2|rs1|funct3|imm[4:0]|opcode.
  - B: imm[12]|imm[10:5]|rs2|rs1|funct3|imm[4:1]|imm[11]|opcode.
  - J: imm[20]|imm[10:1]|imm[11]|imm[19:12]|rd|opcode.
  - U: imm[31:12]|rd|opcode.
- Range checks:
  - I/S: imm in [-2048, 2047].
  - B: imm in [-4096, 4094], imm[0]=0.
  - J: imm in [-2^20, 2^20-2], imm[0]=0.
  - U: imm[11:0]=0, otherwise misaligned.
  - R ignores imm.
  - Range is checked before alignment when both fail.
- Error on accept:
  - Bundle consumed, no write issued, address/count unchanged.
  - err set; err_code latched only if err was 0.
- stop in the same cycle as an accept: the bundle is still encoded and written, then DRAIN.
- start outside IDLE is ignored.
- rst mid-write: pending write is dropped immediately and mem_wr_en=0 next cycle.
- mem_ready high while mem_wr_en=0 has no effect.

Decomposition:
- Shared package holds:
  - format enum (FMT_R..FMT_U);
  - error-code constants;
  - opcode constants OP_IMM=0010011, STORE=0100011, BRANCH=1100011, JAL=1101111, LUI=0110111.
- One combinational sub-module, imm_pack, produces the encoded word plus range/misaligned flags.
- The top holds the FSM, pipeline register and counters.

Test Plan:
- I-type: fmt=1, opcode=0010011, rd=5, rs1=6, funct3=0, imm=-1 -> one write, data 0xFFF30293, addr BASE_ADDR, count=1.
- S-type: fmt=2, opcode=0100011, funct3=2, rs1=1, rs2=2, imm=8 -> 0x0020A423. The core's immediate generator must return 8 from that word.
- B and J back-to-back, mem_ready held high:
  - beq x0,x0,imm=-4 -> 0xFE000EE3 at addr 0.
  - jal rd=1,imm=2048 -> 0x001000EF at addr 1.
  - One write per cycle, no bubbles.
- Error then recovery: B with imm=3 -> no write, err=1, err_code=2. Next I-type bundle is written at the same address. A later fmt=7 bundle leaves err_code=2.
- Backpressure/full with ADDR_W=2:
  - mem_ready low 3 cycles while valid -> data/address stable, in_ready=0.
  - After 4 writes: full=1, count=4, in_ready=0.
  - stop -> IDLE, busy=0.
- Reset during a stalled write (mem_wr_en=1, mem_ready=0): next cycle all outputs 0, state IDLE. start restarts at BASE_ADDR.
